// File: rtl/regfile_wport_arbiter.sv
// Two-source arbiter for the single register-file write port.
// Source A has priority; B is promoted after MAX_WAIT consecutive denied cycles.
module regfile_wport_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              sel,
    output logic              b_starved
);

    localparam logic [3:0] MaxCnt = 4'(MAX_WAIT);

    typedef enum logic {PriA, PriB} state_t;

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    // Ready is held low during reset so no handshake can complete into a discarded write.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                PriA: begin
                    a_ready = a_valid;
                    b_ready = b_valid && !a_valid;
                end
                PriB: begin
                    b_ready = b_valid;
                    a_ready = a_valid && !b_valid;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!b_valid || b_ready) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != MaxCnt) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PriA: if (wait_cnt_d == MaxCnt) state_d = PriB;
            PriB: if (!b_valid || b_ready) state_d = PriA;
            default: state_d = PriA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PriA;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Writes to $0 still complete the handshake but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            sel     <= 1'b0;
        end else if (a_ready) begin
            wr_en   <= (a_addr != '0);
            wr_addr <= a_addr;
            wr_data <= a_data;
            sel     <= 1'b0;
        end else if (b_ready) begin
            wr_en   <= (b_addr != '0);
            wr_addr <= b_addr;
            wr_data <= b_data;
            sel     <= 1'b1;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    assign b_starved = (state_q == PriB);

endmodule
